// File: rtl/fetch_queue.sv
// fetch_queue: RV32I instruction fetch stage and fetch-to-decode buffer.
//
// Owns the program counter, issues word fetches to instruction memory,
// queues returned instructions with their PCs and presents one per cycle
// to decode. Handles decode stalls, branch/jump redirects, and discards
// responses to fetches that were in flight when a redirect arrived.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   imem_req_*        fetch request (valid/ready handshake, word address)
//   imem_rsp_*        in-order fetch response, one per accepted request
//   redirect_valid/pc taken branch / jal / jalr target from execute
//   stall             decode cannot accept the head this cycle
//   id_valid/instr/pc/opcode
//                     queue head to decode; NOP (addi x0,x0,0) when empty

module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [6:0]  id_opcode
);

    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   pc;
    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   rq_pc   [DEPTH];
    logic [PW-1:0] q_rd, q_wr, rq_rd, rq_wr;
    logic [CW-1:0] count, outstanding, drop;

    logic          pop, push, req_fire, room;
    logic [CW:0]   level;

    always_comb begin
        pop   = id_valid && !stall && !redirect_valid;
        // A pop this cycle frees a slot, so issue can continue at one
        // instruction per cycle with a single-cycle memory.
        level = {1'b0, count} + {1'b0, outstanding} - (CW+1)'(pop);
        room  = level < (CW+1)'(DEPTH);
        imem_req_valid = rst_n && !redirect_valid && room;
        imem_req_addr  = pc;
        req_fire       = imem_req_valid && imem_req_ready;
        push           = imem_rsp_valid && !redirect_valid && (drop == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            count       <= '0;
            q_rd        <= '0;
            q_wr        <= '0;
            drop        <= '0;
            outstanding <= '0;
            rq_rd       <= '0;
            rq_wr       <= '0;
        end else begin
            if (redirect_valid) begin
                pc    <= redirect_pc & 32'hFFFF_FFFC;
                count <= '0;
                q_rd  <= '0;
                q_wr  <= '0;
                // drop is always a subset of outstanding, so every fetch
                // still in flight becomes stale; a response arriving this
                // cycle is discarded here and is not counted again.
                drop  <= outstanding - CW'(imem_rsp_valid);
            end else begin
                if (req_fire)
                    pc <= pc + 32'd4;
                count <= count + CW'(push) - CW'(pop);
                if (push)
                    q_wr <= q_wr + 1'b1;
                if (pop)
                    q_rd <= q_rd + 1'b1;
                if (imem_rsp_valid && (drop != '0))
                    drop <= drop - 1'b1;
            end
            // Request-PC side FIFO tracks every accepted request, stale or not.
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (req_fire)
                rq_wr <= rq_wr + 1'b1;
            if (imem_rsp_valid)
                rq_rd <= rq_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire)
            rq_pc[rq_wr] <= pc;
        if (push) begin
            q_pc[q_wr]    <= rq_pc[rq_rd];
            q_instr[q_wr] <= imem_rsp_data;
        end
    end

    always_comb begin
        id_valid  = (count != '0);
        id_instr  = id_valid ? q_instr[q_rd] : NOP;
        id_pc     = id_valid ? q_pc[q_rd] : '0;
        id_opcode = id_instr[6:0];
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [6:0]  id_opcode;

    fetch_queue #(.RESET_PC(32'h0000_0100), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall(stall),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_opcode(id_opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        int unsigned due;
        logic [31:0] addr;
        logic [31:0] epc;
        bit          stale;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        int unsigned n;
        int unsigned stall_m;   // 0/1 fixed, 2 random
        int unsigned ready_m;   // 0/1 fixed, 2 random
        bit          redir;
        logic [31:0] rpc;
        int unsigned exp_reqv;  // 0/1 checked on first cycle, 2 unchecked
    } vec_t;

    mreq_t       mq[$];
    exp_t        sb[$];
    int unsigned cyc;
    int unsigned lat;
    logic [31:0] exp_pc;
    bit          prev_hold;
    logic [31:0] prev_addr;
    int          nvec;
    int          nfail;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A00_0033;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle; entered and left just after a falling edge.
    task automatic tick();
        exp_t  e;
        mreq_t m;
        if (mq.size() > 0 && mq[0].due == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        if (prev_hold && !redirect_valid) begin
            check("req_hold_valid", 32'(imem_req_valid), 32'd1);
            check("req_hold_addr", imem_req_addr, prev_addr);
        end
        if (redirect_valid)
            check("req_during_redirect", 32'(imem_req_valid), 32'd0);
        if (!id_valid) begin
            check("idle_instr", id_instr, 32'h0000_0013);
            check("idle_pc", id_pc, 32'd0);
            check("idle_opcode", 32'(id_opcode), 32'h13);
        end else if (!stall && !redirect_valid) begin
            if (sb.size() == 0) begin
                check("spurious_id_valid", 32'(id_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("id_pc", id_pc, e.pc);
                check("id_instr", id_instr, e.instr);
                check("id_opcode", 32'(id_opcode), 32'(e.instr[6:0]));
            end
        end
        if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, exp_pc);
            mq.push_back('{due: cyc + lat, addr: imem_req_addr, epc: exp_pc, stale: 1'b0});
            exp_pc = exp_pc + 32'd4;
        end
        if (imem_rsp_valid) begin
            m = mq.pop_front();
            if (!redirect_valid && !m.stale)
                sb.push_back('{pc: m.epc, instr: mem_word(m.epc)});
        end
        if (redirect_valid) begin
            foreach (mq[i]) mq[i].stale = 1'b1;
            sb.delete();
            exp_pc = redirect_pc & 32'hFFFF_FFFC;
        end
        prev_hold = imem_req_valid && !imem_req_ready;
        prev_addr = imem_req_addr;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        stall          = 1'b0;
        #1;
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_id_instr", id_instr, 32'h0000_0013);
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_id_opcode", 32'(id_opcode), 32'h13);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        mq.delete();
        sb.delete();
        prev_hold = 1'b0;
        exp_pc    = 32'h0000_0100;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_id_valid", 32'(id_valid), 32'd0);
        check("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
        check("post_rst_req_addr", imem_req_addr, 32'h0000_0100);
    endtask

    task automatic drain();
        int unsigned n;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        n = 0;
        while ((mq.size() != 0 || sb.size() != 0 || id_valid) && n < 20) begin
            tick();
            n++;
        end
        check("drain_sb_empty", 32'(sb.size()), 32'd0);
        check("drain_id_valid", 32'(id_valid), 32'd0);
    endtask

    initial begin
        vec_t        vt[8];
        int unsigned nv, n, prior;
        logic [31:0] snap_pc, snap_instr;
        bit          seen_wrap;

        vt[0] = '{n: 6,  stall_m: 0, ready_m: 1, redir: 1'b0, rpc: 32'h0,         exp_reqv: 2};
        vt[1] = '{n: 5,  stall_m: 2, ready_m: 1, redir: 1'b0, rpc: 32'h0,         exp_reqv: 2};
        vt[2] = '{n: 1,  stall_m: 0, ready_m: 1, redir: 1'b1, rpc: 32'h0000_1000, exp_reqv: 0};
        vt[3] = '{n: 8,  stall_m: 0, ready_m: 2, redir: 1'b0, rpc: 32'h0,         exp_reqv: 2};
        vt[4] = '{n: 1,  stall_m: 2, ready_m: 1, redir: 1'b1, rpc: 32'h0000_2002, exp_reqv: 0};
        vt[5] = '{n: 10, stall_m: 2, ready_m: 2, redir: 1'b0, rpc: 32'h0,         exp_reqv: 2};
        vt[6] = '{n: 1,  stall_m: 0, ready_m: 0, redir: 1'b1, rpc: 32'h0000_3001, exp_reqv: 0};
        vt[7] = '{n: 12, stall_m: 2, ready_m: 2, redir: 1'b0, rpc: 32'h0,         exp_reqv: 2};

        nvec = 0; nfail = 0; cyc = 0; lat = 1;
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        prev_hold = 1'b0; exp_pc = 32'h0000_0100;
        @(negedge clk);
        do_reset();

        // Streaming with 1-cycle memory: one instruction per cycle after warm-up.
        imem_req_ready = 1'b1;
        nv = 0;
        for (int unsigned i = 0; i < 12; i++) begin
            if (i >= 2 && id_valid) nv++;
            tick();
        end
        check("throughput", nv, 32'd10);

        // Stall with a full queue: head stable, no issue.
        stall = 1'b1;
        repeat (3) tick();
        snap_pc    = id_pc;
        snap_instr = id_instr;
        for (int unsigned i = 0; i < 5; i++) begin
            check("stall_id_valid", 32'(id_valid), 32'd1);
            check("stall_id_pc", id_pc, snap_pc);
            check("stall_id_instr", id_instr, snap_instr);
            check("stall_req_valid", 32'(imem_req_valid), 32'd0);
            tick();
        end
        stall = 1'b0;
        repeat (6) tick();

        // Redirect to 0x203 with two fetches outstanding, 3-cycle memory.
        drain();
        lat = 3;
        imem_req_ready = 1'b1;
        n = 0;
        while (mq.size() < 2 && n < 6) begin tick(); n++; end
        check("two_outstanding", 32'(mq.size()), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        tick();
        redirect_valid = 1'b0;
        check("flush_id_valid", 32'(id_valid), 32'd0);
        n = 0;
        while (!id_valid && n < 15) begin tick(); n++; end
        check("first_pc_after_flush", id_pc, 32'h0000_0200);
        repeat (4) tick();

        // Redirect coinciding with a response and a pop.
        drain();
        lat = 1;
        imem_req_ready = 1'b1;
        n = 0;
        while (!(id_valid && mq.size() > 0 && mq[0].due == cyc) && n < 10) begin tick(); n++; end
        check("rsp_pop_setup", 32'(id_valid && mq.size() > 0 && mq[0].due == cyc), 32'd1);
        prior = mq.size();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0400;
        tick();
        redirect_valid = 1'b0;
        check("redir_rsp_pop_id_valid", 32'(id_valid), 32'd0);
        check("redir_rsp_pop_drop", 32'(dut.drop), prior - 32'd1);
        repeat (5) tick();

        // PC wrap across 0xFFFF_FFFC.
        drain();
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF4;
        tick();
        redirect_valid = 1'b0;
        seen_wrap = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (id_valid && id_pc == 32'd0) seen_wrap = 1'b1;
            tick();
        end
        check("pc_wrap_seen", 32'(seen_wrap), 32'd1);

        // Table-driven mixed stall / backpressure / redirect phases, 2-cycle memory.
        drain();
        lat = 2;
        foreach (vt[k]) begin
            for (int unsigned c = 0; c < vt[k].n; c++) begin
                stall          = (vt[k].stall_m == 2) ? 1'($urandom_range(0, 1)) : 1'(vt[k].stall_m);
                imem_req_ready = (vt[k].ready_m == 2) ? 1'($urandom_range(0, 1)) : 1'(vt[k].ready_m);
                redirect_valid = vt[k].redir;
                redirect_pc    = vt[k].rpc;
                if (c == 0 && vt[k].exp_reqv != 2) begin
                    #1;
                    check("table_req_valid", 32'(imem_req_valid), vt[k].exp_reqv);
                end
                tick();
            end
        end
        redirect_valid = 1'b0;

        // Reset with the queue full.
        drain();
        imem_req_ready = 1'b1;
        stall = 1'b1;
        repeat (5) tick();
        check("full_before_reset", 32'(id_valid), 32'd1);
        do_reset();
        repeat (6) tick();

        // Reset while stale responses are pending.
        drain();
        lat = 3;
        imem_req_ready = 1'b1;
        repeat (2) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0800;
        tick();
        redirect_valid = 1'b0;
        check("drop_pending", 32'(dut.drop != '0), 32'd1);
        do_reset();
        imem_req_ready = 1'b1;
        repeat (10) tick();

        drain();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
